// File: rtl/inst_mem_loader.sv
// Instruction memory with a byte-serial program loader and a registered fetch port.
// Optional per-word even parity is compiled in with `define INST_MEM_PARITY_EN.
module inst_mem_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 32,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned NBYTES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    input  logic              load_start,
    input  logic              load_byte_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_end,
    output logic              load_ready,
    output logic              load_busy,
    output logic [CNT_W-1:0]  load_count,
    output logic              parity_err
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned CMP_W  = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
    localparam logic [CNT_W-1:0]  DepthC    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LastWordC = CNT_W'(DEPTH - 1);
    localparam logic [BIDX_W-1:0] LastByteC = BIDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic [BIDX_W-1:0]  bidx_q, bidx_d;
    logic [DATA_W-1:0]  wbuf_q, wbuf_d;
    logic [CNT_W-1:0]   count_d;
    logic               ready_d;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_word;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rd_word;
    logic [CMP_W-1:0]   addr_ext, count_ext;
    logic               addr_ok;
    logic               par_bad;
    logic               fault;

    // Byte lane placement: first byte of a word goes to the most significant lane.
    always_comb begin
        wr_word = wbuf_q;
        wr_word[(NBYTES - 1 - int'(bidx_q)) * 8 +: 8] = load_byte;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bidx_d  = bidx_q;
        wbuf_d  = wbuf_q;
        count_d = load_count;
        wr_en   = 1'b0;
        if (load_start) begin
            state_d = StLoad;
            ptr_d   = '0;
            bidx_d  = '0;
            wbuf_d  = '0;
            count_d = '0;
        end else if (state_q == StLoad) begin
            if (load_byte_valid && (ptr_q < DepthC)) begin
                if (bidx_q == LastByteC) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = ptr_q + 1'b1;
                    bidx_d  = '0;
                    if (ptr_q == LastWordC) begin
                        state_d = StRun;
                    end
                end else begin
                    wbuf_d = wr_word;
                    bidx_d = bidx_q + 1'b1;
                end
            end
            // The byte in the same cycle is consumed first; a partial word is dropped.
            if (load_end) begin
                state_d = StRun;
            end
        end
        ready_d = (state_d == StLoad) && (ptr_d < DepthC);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q[IDX_W-1:0]] <= wr_word;
        end
    end

    assign rd_word   = mem[fetch_addr[IDX_W-1:0]];
    assign addr_ext  = CMP_W'(fetch_addr);
    assign count_ext = CMP_W'(load_count);
    // load_count never exceeds DEPTH, so this range check also bounds the index.
    assign addr_ok   = (state_q == StRun) && (addr_ext < count_ext);
    assign fault     = !addr_ok || par_bad;

`ifdef INST_MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[ptr_q[IDX_W-1:0]] <= ^wr_word;
        end
    end

    assign par_bad = addr_ok && (par_mem[fetch_addr[IDX_W-1:0]] != (^rd_word));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else if (load_start) begin
            parity_err_q <= 1'b0;
        end else if (fetch_req && par_bad) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            bidx_q      <= '0;
            wbuf_q      <= '0;
            load_count  <= '0;
            load_ready  <= 1'b0;
            load_busy   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            fetch_fault <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            bidx_q      <= bidx_d;
            wbuf_q      <= wbuf_d;
            load_count  <= count_d;
            load_ready  <= ready_d;
            load_busy   <= (state_d == StLoad);
            fetch_valid <= fetch_req;
            if (fetch_req) begin
                fetch_fault <= fault;
                fetch_data  <= fault ? '0 : rd_word;
            end
        end
    end

endmodule
